// File: rtl/regfile_write_arbiter_if.sv
// Bundles the result-source handshakes, decode hazard query and register-file write port.
// Latency: none, wiring only.
// Backpressure: alu_ready / ld_ready flow from the arbiter back to the producers.
interface regfile_write_arbiter_if #(
  parameter int Width = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [Width-1:0] alu_data;
  logic             alu_ready;

  logic             ld_valid;
  logic [4:0]       ld_rd;
  logic [Width-1:0] ld_data;
  logic             ld_ready;

  logic [4:0]       query_rd1;
  logic [4:0]       query_rd2;
  logic             hazard;

  logic             RegWrite;
  logic [4:0]       WriteDataTrig;
  logic [Width-1:0] WD1;
  logic [CNT_W-1:0] fifo_count;

  // Producer / decode side.
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, query_rd1, query_rd2,
    input  alu_ready, ld_ready, hazard, RegWrite, WriteDataTrig, WD1, fifo_count
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, query_rd1, query_rd2,
    output alu_ready, ld_ready, hazard, RegWrite, WriteDataTrig, WD1, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Merges ALU results and FIFO-buffered load results onto the single register-file write port.
// Latency: one cycle from selection to RegWrite/WriteDataTrig/WD1.
// Backpressure: alu_ready drops for one cycle after STARVE_LIMIT ALU wins over a waiting load; ld_ready = FIFO not full.
module regfile_write_arbiter #(
  parameter int Width        = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic              clk,
  input logic              reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]       rd;
    logic [Width-1:0] data;
  } wr_t;

  wr_t              mem_q [DEPTH];
  wr_t              mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [Width-1:0] wdata_q, wdata_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             alu_ready;
  logic             ld_ready;
  logic             alu_wr;
  logic             pop;
  logic             push;
  logic             hazard;
  logic [PTR_W-1:0] offs;
  wr_t              head;

  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] q1, input logic [4:0] q2);
    return ((q1 != 5'd0) && (rd == q1)) || ((q2 != 5'd0) && (rd == q2));
  endfunction

  // Arbitration: the ALU wins unless it has starved a waiting load; x0 results never take the port.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CNT_FULL);
    ld_ready   = !fifo_full;
    // A saturated starve counter implies a non-empty FIFO, so this also covers the ALU grant rule.
    alu_ready  = !((starve_q == STV_MAX) && !fifo_empty);
    alu_wr     = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
    pop        = !fifo_empty && !alu_wr;
    push       = bus.ld_valid && ld_ready && (bus.ld_rd != 5'd0);
    head       = mem_q[rd_ptr_q];
  end

  // FIFO storage, pointers, occupancy and starve counter next-state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: bus.ld_rd, data: bus.ld_data};
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_wr && (starve_q != STV_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Write port next-state: address and data hold when nothing is selected.
  always_comb begin
    regwrite_d = alu_wr || pop;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (alu_wr) begin
      waddr_d = bus.alu_rd;
      wdata_d = bus.alu_data;
    end else if (pop) begin
      waddr_d = head.rd;
      wdata_d = head.data;
    end
  end

  // Hazard: any occupied FIFO slot or the load entering this cycle matches a decode source.
  always_comb begin
    hazard = 1'b0;
    offs   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(offs) < cnt_q) && rd_hit(mem_q[i].rd, bus.query_rd1, bus.query_rd2)) begin
        hazard = 1'b1;
      end
    end
    if (push && rd_hit(bus.ld_rd, bus.query_rd1, bus.query_rd2)) begin
      hazard = 1'b1;
    end
  end

  // State registers; reset drops queued loads and any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.alu_ready     = alu_ready;
  assign bus.ld_ready      = ld_ready;
  assign bus.hazard        = hazard;
  assign bus.RegWrite      = regwrite_q;
  assign bus.WriteDataTrig = waddr_q;
  assign bus.WD1           = wdata_q;
  assign bus.fifo_count    = cnt_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: scripted scenarios, write order tracked by a scoreboard.
// Latency: expectations are queued when the source is selected and checked one cycle later.
// Backpressure: producers hold their inputs while alu_ready / ld_ready are low.
module tb_regfile_write_arbiter;
  localparam int W = 32;

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  wr_t  sb[$];

  regfile_write_arbiter_if #(.Width(W), .DEPTH(4)) bus ();

  regfile_write_arbiter #(.Width(W), .DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Write-port monitor: every write must be the next expected one and never target x0.
  always @(negedge clk) begin
    if (bus.RegWrite === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h, expected no write", bus.WriteDataTrig, bus.WD1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if ({bus.WriteDataTrig, bus.WD1} !== e) begin
          errors++;
          $display("FAIL write_order: got rd=%0d data=%0h, expected rd=%0d data=%0h",
                   bus.WriteDataTrig, bus.WD1, e.rd, e.data);
        end
      end
      checks++;
      if (bus.WriteDataTrig === 5'd0) begin
        errors++;
        $display("FAIL x0_write: got rd=%0d, expected nonzero", bus.WriteDataTrig);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.query_rd1 = '0;   bus.query_rd2 = '0;
  endtask

  // Four ALU results back to back with four loads arriving alongside; leaves the FIFO full, starve at limit.
  task automatic fill(input logic [4:0] ld_base, input logic [4:0] alu_base);
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = alu_base + 5'(i); bus.alu_data = 32'hA0 + 32'(i);
      bus.ld_valid  = 1'b1; bus.ld_rd  = ld_base + 5'(i);  bus.ld_data  = 32'(17 * (i + 1));
      sb.push_back({alu_base + 5'(i), 32'hA0 + 32'(i)});
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0b expected 0", bus.RegWrite); end
    checks++; if (bus.WriteDataTrig !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", bus.WriteDataTrig); end
    checks++; if (bus.WD1 !== 32'd0) begin errors++; $display("FAIL reset_wd1: got %0h expected 0", bus.WD1); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %0b expected 1", bus.ld_ready); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %0b expected 0", bus.hazard); end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %0b expected 1", bus.alu_ready); end
  endtask

  task automatic test_alu_only();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000ABCD;
    sb.push_back({5'd5, 32'h0000ABCD});
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %0b expected 1", bus.alu_ready); end
    tick();
    idle();
    checks++;
    if ({bus.RegWrite, bus.WriteDataTrig, bus.WD1} !== {1'b1, 5'd5, 32'h0000ABCD}) begin
      errors++;
      $display("FAIL alu_write: got we=%0b rd=%0d data=%0h expected we=1 rd=5 data=abcd", bus.RegWrite, bus.WriteDataTrig, bus.WD1);
    end
    tick();
    checks++;
    if ({bus.RegWrite, bus.WriteDataTrig, bus.WD1} !== {1'b0, 5'd5, 32'h0000ABCD}) begin
      errors++;
      $display("FAIL idle_hold: got we=%0b rd=%0d data=%0h expected we=0 rd=5 data=abcd", bus.RegWrite, bus.WriteDataTrig, bus.WD1);
    end
  endtask

  task automatic test_starve();
    fill(5'd1, 5'd10);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd14; bus.alu_data = 32'hA4;
    bus.ld_valid  = 1'b0;
    #1;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", bus.fifo_count); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready: got %0b expected 0", bus.ld_ready); end
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL starve_stall: got %0b expected 0", bus.alu_ready); end
    sb.push_back({5'd1, 32'h11});
    tick();
    checks++;
    if ({bus.RegWrite, bus.WriteDataTrig, bus.WD1} !== {1'b1, 5'd1, 32'h11}) begin
      errors++;
      $display("FAIL starve_pop_write: got we=%0b rd=%0d data=%0h expected we=1 rd=1 data=11", bus.RegWrite, bus.WriteDataTrig, bus.WD1);
    end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL alu_resume_ready: got %0b expected 1", bus.alu_ready); end
    sb.push_back({5'd14, 32'hA4});
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.WriteDataTrig !== 5'd14) begin errors++; $display("FAIL alu_resume_write: got rd=%0d expected 14", bus.WriteDataTrig); end
    for (int i = 2; i <= 4; i++) begin
      sb.push_back({5'(i), 32'(17 * i)});
      tick();
    end
    tick();
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL starve_drain: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_full_pushpop();
    fill(5'd21, 5'd15);
    idle();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd25; bus.ld_data = 32'h55;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %0b expected 0", bus.ld_ready); end
    sb.push_back({5'd21, 32'h11});
    tick();
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL pushpop_count_dec: got %0d expected 3", bus.fifo_count); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL pushpop_ld_ready: got %0b expected 1", bus.ld_ready); end
    sb.push_back({5'd22, 32'h22});
    tick();
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL pushpop_count_hold: got %0d expected 3", bus.fifo_count); end
    bus.ld_valid = 1'b0;
    sb.push_back({5'd23, 32'h33}); tick();
    sb.push_back({5'd24, 32'h44}); tick();
    sb.push_back({5'd25, 32'h55}); tick();
    tick();
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL pushpop_drain: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_x0();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC0DE;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd7;  bus.ld_data  = 32'h77;
    sb.push_back({5'd12, 32'hC0DE});
    tick();
    bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
    bus.ld_valid = 1'b0;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_accept: got %0b expected 1", bus.alu_ready); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL x0_queued: got %0d expected 1", bus.fifo_count); end
    sb.push_back({5'd7, 32'h77});
    tick();
    idle();
    checks++;
    if ({bus.RegWrite, bus.WriteDataTrig, bus.WD1} !== {1'b1, 5'd7, 32'h77}) begin
      errors++;
      $display("FAIL x0_pop_write: got we=%0b rd=%0d data=%0h expected we=1 rd=7 data=77", bus.RegWrite, bus.WriteDataTrig, bus.WD1);
    end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL x0_count: got %0d expected 0", bus.fifo_count); end
    tick();
  endtask

  task automatic test_hazard();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'hD0;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd9;  bus.ld_data  = 32'h99;
    bus.query_rd1 = 5'd9;
    sb.push_back({5'd13, 32'hD0});
    #1;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL hazard_push: got %0b expected 1", bus.hazard); end
    tick();
    bus.alu_rd = 5'd14; bus.alu_data = 32'hE0;
    bus.ld_valid = 1'b0;
    sb.push_back({5'd14, 32'hE0});
    #1;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL hazard_queued: got %0b expected 1", bus.hazard); end
    bus.query_rd1 = 5'd3; bus.query_rd2 = 5'd0;
    #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL hazard_nomatch: got %0b expected 0", bus.hazard); end
    bus.query_rd1 = 5'd0; bus.query_rd2 = 5'd9;
    #1;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL hazard_rd2: got %0b expected 1", bus.hazard); end
    tick();
    idle();
    bus.query_rd1 = 5'd9;
    sb.push_back({5'd9, 32'h99});
    #1;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL hazard_until_pop: got %0b expected 1", bus.hazard); end
    tick();
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL hazard_after_pop: got %0b expected 0", bus.hazard); end
    checks++; if (bus.WriteDataTrig !== 5'd9) begin errors++; $display("FAIL hazard_pop_write: got rd=%0d expected 9", bus.WriteDataTrig); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd20 + 5'(i); bus.alu_data = 32'hB0 + 32'(i);
      bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd1 + 5'(i);  bus.ld_data  = 32'h100 + 32'(i);
      sb.push_back({5'd20 + 5'(i), 32'hB0 + 32'(i)});
      tick();
    end
    checks++;
    if ({bus.fifo_count, bus.RegWrite} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_state: got count=%0d we=%0b expected count=3 we=1", bus.fifo_count, bus.RegWrite);
    end
    // Traffic stays active during reset; the ALU result offered now must be dropped.
    reset = 1'b1;
    bus.alu_rd = 5'd23; bus.alu_data = 32'hB3;
    bus.ld_rd  = 5'd4;  bus.ld_data  = 32'h103;
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL mid_reset_regwrite: got %0b expected 0", bus.RegWrite); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ld_ready: got %0b expected 1", bus.ld_ready); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL mid_reset_hazard: got %0b expected 0", bus.hazard); end
    checks++; if (bus.WD1 !== 32'd0) begin errors++; $display("FAIL mid_reset_wd1: got %0h expected 0", bus.WD1); end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_starve();
    test_full_pushpop();
    test_x0();
    test_hazard();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending writes expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Producer side of the register file's single write port.
- Merges two result sources into one write per cycle, driven onto RegWrite / WriteDataTrig / WD1:
  - single-cycle ALU results;
  - variable-latency load results, buffered in a small FIFO.
- Sits between execute/memory and the Registerfile write inputs.
- Also reports read-after-write hazards for registers with queued load results.

Parameters:
- Width, 32, data width of results and WD1.
- DEPTH, 4, load-result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 3, consecutive ALU-granted cycles with a non-empty FIFO before the ALU is stalled for one cycle.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  Width  ALU result.
- alu_ready  output  1  ALU result accepted this cycle (combinational).
- ld_valid  input  1  load result present.
- ld_rd  input  5  load destination register.
- ld_data  input  Width  load data.
- ld_ready  output  1  FIFO can accept; equals not full (registered state only).
- query_rd1  input  5  source register 1 of the instruction in decode.
- query_rd2  input  5  source register 2 of the instruction in decode.
- hazard  output  1  a queued load targets query_rd1 or query_rd2 (combinational).
- RegWrite  output  1  registered write enable to Registerfile.
- WriteDataTrig  output  5  registered write address.
- WD1  output  Width  registered write data.
- fifo_count  output  log2(DEPTH)+1  entries currently queued.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - RegWrite=0, WriteDataTrig=0, WD1=0.
  - FIFO pointers and count=0; starve counter=0.
  - ld_ready=1, hazard=0.
  - An in-flight write is dropped.
- Write port timing:
  - Exactly one source is selected per cycle.
  - The selection appears on RegWrite / WriteDataTrig / WD1 one cycle later (latency 1).
  - If nothing is selected, RegWrite=0; WriteDataTrig and WD1 hold their previous values.
- Arbitration each cycle:
  - ALU wins if alu_valid and starve counter < STARVE_LIMIT.
  - Otherwise the FIFO head is popped if the FIFO is non-empty.
  - alu_ready = not(starve counter == STARVE_LIMIT and FIFO non-empty).
  - When alu_ready=0 the ALU producer holds its inputs.
- Starve counter:
  - Increments when the ALU is granted while the FIFO is non-empty.
  - Clears on any FIFO pop or whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - Effect: at most STARVE_LIMIT ALU writes occur between FIFO pops.
- FIFO:
  - Push when ld_valid and ld_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When full, ld_ready=0 even if a pop occurs that cycle (no bypass).
  - Pointers wrap modulo DEPTH.
  - A pop while empty never occurs.
- Register x0:
  - Results with rd==0 are accepted (alu_ready/ld_ready honoured) but discarded.
  - Discarded results are not queued and generate no write.
  - A discarded ALU result does not consume the port, so the FIFO may pop that cycle.
- Hazard:
  - Asserted if any valid FIFO entry's rd equals a non-zero query_rd1 or query_rd2.
  - Also asserted for a load being pushed this cycle.
  - Not asserted for the registered write currently on the port (Registerfile writes it this edge).
- Ordering:
  - Loads retire in FIFO order.
  - If an ALU and a queued load target the same rd, the later-retiring write wins; decode uses hazard to stall.
  - No write combining.

Test Plan:
- Reset:
  - Assert reset mid-traffic with 3 entries queued and RegWrite=1.
  - Next cycle: RegWrite=0, fifo_count=0, ld_ready=1, hazard=0, WD1=0.
- ALU only:
  - alu_valid with rd=5, data=0x0000ABCD.
  - One cycle later: RegWrite=1, WriteDataTrig=5, WD1=0x0000ABCD; alu_ready stays 1.
- Load queueing and full:
  - Push 4 loads (rd=1..4, data=0x11..0x44) while alu_valid is held continuously.
  - fifo_count=4, ld_ready=0.
  - After STARVE_LIMIT=3 ALU grants, alu_ready=0 for one cycle.
  - Next write is rd=1, data=0x11; the ALU then resumes.
- Simultaneous push/pop at full:
  - FIFO full, ALU idle, ld_valid=1.
  - ld_ready=0 that cycle; count goes 4->3; the new load is pushed the following cycle.
- x0 discard:
  - alu_rd=0 while the FIFO holds rd=7.
  - The FIFO pops that cycle; the next write is rd=7, and no write to register 0 ever occurs.
- Hazard:
  - Queue a load with rd=9; drive query_rd1=9 -> hazard=1.
  - query_rd2=0 with query_rd1=3 -> hazard=0.
  - Hazard drops the cycle after rd=9 is popped.
